// File: rtl/prom_ctrl_pkg.sv
// Shared types and constants for the PROM lookup scheduler.
package prom_ctrl_pkg;

    localparam int unsigned PROM_AW = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    typedef logic [PROM_AW-1:0] prom_addr_t;

    localparam prom_addr_t SWEEP_LAST = '1;

endpackage

// File: rtl/prom_bit_fn.sv
// Combinational 9-input, 1-output PROM bit function.
//   addr : PROM address (bits 6 and 8 do not affect the result)
//   y_c  : PROM bit at addr
module prom_bit_fn
    import prom_ctrl_pkg::*;
(
    input  prom_addr_t addr,
    output logic       y_c
);

    // Bits 6 and 8 are don't-care inputs of this function.
    logic unused_bits;
    assign unused_bits = ^{addr[6], addr[8]};

    // x0 set: one only when x1..x3 are all zero; x0 clear: one when any of x1..x5,x7 is set.
    assign y_c = addr[0] ? ~|addr[3:1] : |{addr[7], addr[5:1]};

endmodule

// File: rtl/prom_lookup_sched.sv
// Round-robin shared access to one PROM bit function, plus a full-address
// self-sweep that counts ones for signature checking.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid    : per-requester lookup request
//   req_addr     : per-requester address, slice i = [9*i+8:9*i]
//   req_ready    : one-hot grant (combinational), accept = valid & ready
//   resp_valid   : one-hot response pulse, one cycle after accept
//   resp_data    : PROM bit for the flagged response
//   sweep_start  : pulse to start a 512-address sweep from IDLE
//   sweep_busy   : high while sweeping
//   sweep_done   : one-cycle pulse at sweep completion
//   ones_count   : ones counted in the last sweep
module prom_lookup_sched
    import prom_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CW   = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*PROM_AW-1:0] req_addr,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         resp_valid,
    output logic                    resp_data,
    input  logic                    sweep_start,
    output logic                    sweep_busy,
    output logic                    sweep_done,
    output logic [CW-1:0]           ones_count
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_t    state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    prom_addr_t      sweep_addr_q, sweep_addr_d;
    logic [CW-1:0]   ones_q, ones_d;
    logic [NREQ-1:0] resp_valid_q, resp_valid_d;
    logic            resp_data_q, resp_data_d;

    logic            grant_en_c;
    logic            gnt_found_c;
    logic [PW-1:0]   gnt_idx_c;
    logic [NREQ-1:0] gnt_c;
    prom_addr_t      gnt_addr_c;
    prom_addr_t      prom_in_c;
    logic            prom_y_c;

    // Grants only in IDLE, out of reset, and never in the cycle a sweep is requested.
    assign grant_en_c = rst_n && (state_q == IDLE) && !sweep_start;

    // Round-robin pick: first pass looks at or after the pointer, second pass wraps.
    always_comb begin
        gnt_found_c = 1'b0;
        gnt_idx_c   = '0;
        gnt_c       = '0;
        gnt_addr_c  = '0;
        if (grant_en_c) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!gnt_found_c && req_valid[i] && (PW'(i) >= ptr_q)) begin
                    gnt_found_c = 1'b1;
                    gnt_idx_c   = PW'(i);
                    gnt_addr_c  = req_addr[i*PROM_AW +: PROM_AW];
                end
            end
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!gnt_found_c && req_valid[i]) begin
                    gnt_found_c = 1'b1;
                    gnt_idx_c   = PW'(i);
                    gnt_addr_c  = req_addr[i*PROM_AW +: PROM_AW];
                end
            end
            if (gnt_found_c) begin
                gnt_c[gnt_idx_c] = 1'b1;
            end
        end
    end

    // Single function instance shared between the sweep walker and the granted requester.
    assign prom_in_c = (state_q == SWEEP) ? sweep_addr_q : gnt_addr_c;

    prom_bit_fn u_prom_bit_fn (
        .addr (prom_in_c),
        .y_c  (prom_y_c)
    );

    // Next-state, pointer, sweep and response logic.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        sweep_addr_d = sweep_addr_q;
        ones_d       = ones_q;
        resp_valid_d = '0;
        resp_data_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    state_d      = SWEEP;
                    sweep_addr_d = '0;
                    ones_d       = '0;
                end else if (gnt_found_c) begin
                    ptr_d        = (32'(gnt_idx_c) == NREQ - 1) ? '0 : gnt_idx_c + PW'(1);
                    resp_valid_d = gnt_c;
                    resp_data_d  = prom_y_c;
                end
            end
            SWEEP: begin
                ones_d       = ones_q + CW'(prom_y_c);
                sweep_addr_d = sweep_addr_q + prom_addr_t'(1);
                if (sweep_addr_q == SWEEP_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            sweep_addr_q <= '0;
            ones_q       <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            sweep_addr_q <= sweep_addr_d;
            ones_q       <= ones_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign req_ready  = gnt_c;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign sweep_busy = (state_q == SWEEP);
    assign sweep_done = (state_q == DONE);
    assign ones_count = ones_q;

endmodule
